// File: rtl/id_stage_if.sv
// Fetch/EX/WB-facing signal bundle of the decode stage.
// slave = the decode stage itself, master = whoever drives it (fetch/EX/WB or a bench).
interface id_stage_if #(parameter int PC_WIDTH = 32);
  logic [31:0]         IR_in;
  logic [PC_WIDTH-1:0] PC_in;
  logic                flush;
  logic                EX_memread;
  logic [4:0]          EX_rt;
  logic                WB_we;
  logic [4:0]          WB_addr;
  logic [31:0]         WB_data;

  logic                PC_EN;
  logic                J, JAL, JR;
  logic [PC_WIDTH-1:0] Jaddr;
  logic [31:0]         rs_data, rt_data, imm_ext;
  logic [4:0]          dest;
  logic                reg_write, mem_read, mem_write, alu_src, branch, link;
  logic [2:0]          alu_op;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] pc_out;

  modport slave (
    input  IR_in, PC_in, flush, EX_memread, EX_rt, WB_we, WB_addr, WB_data,
    output PC_EN, J, JAL, JR, Jaddr, rs_data, rt_data, imm_ext, dest,
           reg_write, mem_read, mem_write, alu_src, branch, link, alu_op,
           br_target, pc_out
  );

  modport master (
    output IR_in, PC_in, flush, EX_memread, EX_rt, WB_we, WB_addr, WB_data,
    input  PC_EN, J, JAL, JR, Jaddr, rs_data, rt_data, imm_ext, dest,
           reg_write, mem_read, mem_write, alu_src, branch, link, alu_op,
           br_target, pc_out
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 32x32 register file with write-through read,
// main decoder, ID-resolved jumps, load-use stall and ID/EX latch.
module id_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic       clk,
  input  logic       CLR,
  id_stage_if.slave  bus
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR = 3'b011, ALU_SLT = 3'b100;

  typedef struct packed {
    logic                reg_write, mem_read, mem_write, alu_src, branch, link;
    logic [2:0]          alu_op;
    logic [4:0]          dest;
    logic [31:0]         rs_data, rt_data, imm_ext;
    logic [PC_WIDTH-1:0] br_target, pc;
  } idex_t;

  logic [31:0]         ir_q;
  logic [PC_WIDTH-1:0] pc_q;
  idex_t               idex_q, dec, idex_nxt;
  logic [31:0]         rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, imm;
  logic        valid, reads_rt, is_j, is_jal, is_jr, stall, jump;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm   = {{16{ir_q[15]}}, ir_q[15:0]};

  // Same-cycle WB write is forwarded so a reader never sees the stale value.
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (bus.WB_we && bus.WB_addr == rs) ? bus.WB_data : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (bus.WB_we && bus.WB_addr == rt) ? bus.WB_data : rf[rt];

  always_comb begin
    dec      = '0;
    valid    = 1'b1;
    reads_rt = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    case (op)
      OP_R: begin
        reads_rt      = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = rd;
        case (funct)
          F_ADD:   dec.alu_op = ALU_ADD;
          F_SUB:   dec.alu_op = ALU_SUB;
          F_AND:   dec.alu_op = ALU_AND;
          F_OR:    dec.alu_op = ALU_OR;
          F_SLT:   dec.alu_op = ALU_SLT;
          F_JR:    begin is_jr = 1'b1; reads_rt = 1'b0; dec.reg_write = 1'b0; dec.dest = 5'd0; end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.dest = rt; end
      OP_LW:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.dest = rt; end
      OP_SW:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; reads_rt = 1'b1; end
      OP_BEQ:  begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; reads_rt = 1'b1; end
      OP_J:    is_j = 1'b1;
      OP_JAL:  begin is_jal = 1'b1; dec.reg_write = 1'b1; dec.link = 1'b1; dec.dest = 5'd31; end
      default: valid = 1'b0;
    endcase
    dec.rs_data   = rs_val;
    dec.rt_data   = rt_val;
    dec.imm_ext   = imm;
    dec.br_target = pc_q + PC_WIDTH'(1) + PC_WIDTH'(imm);
    dec.pc        = pc_q;
    // Undecoded encodings leave ID/EX looking exactly like a bubble.
    idex_nxt      = valid ? dec : '0;
  end

  assign stall = bus.EX_memread && (bus.EX_rt != 5'd0) &&
                 ((bus.EX_rt == rs) || ((bus.EX_rt == rt) && reads_rt));
  assign bus.PC_EN = !stall;
  assign bus.J     = is_j   && !stall && !bus.flush;
  assign bus.JAL   = is_jal && !stall && !bus.flush;
  assign bus.JR    = is_jr  && !stall && !bus.flush;
  assign jump      = bus.J || bus.JAL || bus.JR;
  assign bus.Jaddr = is_jr ? PC_WIDTH'(rs_val) : PC_WIDTH'(ir_q[25:0]);

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.WB_we && bus.WB_addr != 5'd0) begin
      rf[bus.WB_addr] <= bus.WB_data;
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      ir_q   <= '0;
      pc_q   <= '0;
      idex_q <= '0;
    end else if (bus.flush) begin
      ir_q   <= '0;
      pc_q   <= '0;
      idex_q <= '0;
    end else if (stall) begin
      idex_q <= '0;
    end else if (jump) begin
      // The instruction fetched behind a jump is wrong-path; squash it.
      ir_q   <= '0;
      pc_q   <= '0;
      idex_q <= idex_nxt;
    end else begin
      ir_q   <= bus.IR_in;
      pc_q   <= bus.PC_in;
      idex_q <= idex_nxt;
    end
  end

  assign bus.reg_write = idex_q.reg_write;
  assign bus.mem_read  = idex_q.mem_read;
  assign bus.mem_write = idex_q.mem_write;
  assign bus.alu_src   = idex_q.alu_src;
  assign bus.branch    = idex_q.branch;
  assign bus.link      = idex_q.link;
  assign bus.alu_op    = idex_q.alu_op;
  assign bus.dest      = idex_q.dest;
  assign bus.rs_data   = idex_q.rs_data;
  assign bus.rt_data   = idex_q.rt_data;
  assign bus.imm_ext   = idex_q.imm_ext;
  assign bus.br_target = idex_q.br_target;
  assign bus.pc_out    = idex_q.pc;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, load-use stall, jumps, flush, async clear.
module tb_id_stage;
  logic clk = 1'b0;
  logic CLR = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_stage_if #(.PC_WIDTH(32)) bus();
  id_stage #(.PC_WIDTH(32)) dut (.clk(clk), .CLR(CLR), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
    bus.IR_in = ir;
    bus.PC_in = pc;
  endtask

  initial begin
    drive(32'h0, 32'h0);
    bus.flush = 0; bus.EX_memread = 0; bus.EX_rt = 0;
    bus.WB_we = 0; bus.WB_addr = 0; bus.WB_data = 0;
    repeat (2) tick();
    chk("rst_pc_en", bus.PC_EN, 1);
    chk("rst_jumps", {bus.J, bus.JAL, bus.JR}, 0);
    chk("rst_ctl", {bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src, bus.branch, bus.link}, 0);
    chk("rst_dest", bus.dest, 0);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_br_target", bus.br_target, 0);
    CLR = 0;

    // preload r2=0x22, r4=0x44 while IF/ID holds NOPs
    bus.WB_we = 1; bus.WB_addr = 2; bus.WB_data = 32'h22; tick();
    bus.WB_addr = 4; bus.WB_data = 32'h44; tick();
    bus.WB_we = 0;
    chk("nop_bubble_ctl", {bus.reg_write, bus.alu_src, bus.link, bus.alu_op}, 0);
    chk("nop_bubble_data", {bus.imm_ext | bus.br_target | bus.pc_out | bus.rs_data}, 0);

    // addi r1,r0,5 at PC 3
    drive(32'h20010005, 3); tick();
    drive(0, 0); tick();
    chk("addi_dest", bus.dest, 1);
    chk("addi_rw_src", {bus.reg_write, bus.alu_src, bus.mem_read}, 3'b110);
    chk("addi_imm", bus.imm_ext, 5);
    chk("addi_aluop", bus.alu_op, 0);
    chk("addi_pc", bus.pc_out, 3);
    chk("addi_brt", bus.br_target, 9);

    // load-use on add r3,r2,r4
    drive(32'h00441820, 4); tick();
    drive(0, 0);
    bus.EX_memread = 1; bus.EX_rt = 2; #1;
    chk("lu_rs_stall", bus.PC_EN, 0);
    bus.EX_rt = 4; #1;
    chk("lu_rt_stall", bus.PC_EN, 0);
    bus.EX_rt = 0; #1;
    chk("lu_r0_nostall", bus.PC_EN, 1);
    bus.EX_rt = 2; tick();
    chk("lu_bubble", {bus.reg_write, bus.dest}, 0);
    bus.EX_memread = 0; #1;
    chk("lu_resume", bus.PC_EN, 1);
    tick();
    chk("add_dest", bus.dest, 3);
    chk("add_rw", {bus.reg_write, bus.alu_src}, 2'b10);
    chk("add_rs", bus.rs_data, 32'h22);
    chk("add_rt", bus.rt_data, 32'h44);
    chk("add_pc", bus.pc_out, 4);

    // slt r6,r2,r4
    drive(32'h0044302A, 5); tick();
    drive(0, 0); tick();
    chk("slt_aluop", bus.alu_op, 3'b100);
    chk("slt_dest", bus.dest, 6);

    // jal 0x10 at PC 7, wrong-path addi behind it
    drive(32'h0C000010, 7); tick();
    drive(32'h20010005, 8); #1;
    chk("jal_flags", {bus.J, bus.JAL, bus.JR}, 3'b010);
    chk("jal_addr", bus.Jaddr, 32'h10);
    chk("jal_pc_en", bus.PC_EN, 1);
    bus.flush = 1; #1;
    chk("jal_flush_gate", bus.JAL, 0);
    bus.flush = 0; tick();
    chk("jal_dest", bus.dest, 31);
    chk("jal_link_rw", {bus.link, bus.reg_write}, 2'b11);
    chk("jal_pc", bus.pc_out, 7);
    chk("jal_squash_comb", bus.JAL, 0);
    drive(0, 0); tick();
    chk("jal_squash_idex", bus.reg_write, 0);

    // jr r5 with WB bypass
    drive(32'h00A00008, 11); tick();
    drive(0, 0);
    bus.WB_we = 1; bus.WB_addr = 5; bus.WB_data = 32'h1C; #1;
    chk("jr_flag", {bus.J, bus.JAL, bus.JR}, 3'b001);
    chk("jr_bypass", bus.Jaddr, 32'h1C);
    bus.EX_memread = 1; bus.EX_rt = 5; #1;
    chk("jr_stall_jr", bus.JR, 0);
    chk("jr_stall_pc_en", bus.PC_EN, 0);
    bus.EX_memread = 0; bus.WB_we = 0; #1;
    chk("jr_nobypass", bus.Jaddr, 0);
    tick();
    chk("jr_idex", {bus.reg_write, bus.link, bus.dest}, 0);
    chk("jr_pc", bus.pc_out, 11);
    chk("jr_squash", bus.JR, 0);

    // beq r1,r2,-2 at PC 9 then flush
    drive(32'h1022FFFE, 9); tick();
    drive(32'h00441820, 10); tick();
    chk("beq_brt", bus.br_target, 8);
    chk("beq_branch_rw", {bus.branch, bus.reg_write}, 2'b10);
    chk("beq_aluop", bus.alu_op, 3'b001);
    chk("beq_imm", bus.imm_ext, 32'hFFFFFFFE);
    chk("beq_rt", bus.rt_data, 32'h22);
    bus.flush = 1; drive(32'h20010005, 11); tick();
    chk("flush_bubble", {bus.branch, bus.reg_write, bus.dest}, 0);
    bus.flush = 0; drive(0, 0); tick();
    chk("flush_ifid_nop", {bus.reg_write, bus.dest}, 0);

    // flush and stall together: held add is discarded
    drive(32'h00441820, 12); tick();
    drive(0, 0);
    bus.EX_memread = 1; bus.EX_rt = 2; bus.flush = 1; #1;
    chk("fs_pc_en", bus.PC_EN, 0);
    tick();
    bus.EX_memread = 0; bus.flush = 0; #1;
    chk("fs_resume", bus.PC_EN, 1);
    tick();
    chk("fs_discard", {bus.reg_write, bus.dest}, 0);

    // write to r0 is ignored and never bypassed
    drive(32'h00001820, 0);
    bus.WB_we = 1; bus.WB_addr = 0; bus.WB_data = 32'hDEAD; tick();
    drive(0, 0); tick();
    bus.WB_we = 0;
    chk("r0_rs", bus.rs_data, 0);
    chk("r0_rt", bus.rt_data, 0);

    // async clear mid-stall
    drive(32'h20010005, 20); tick();
    drive(32'h00441820, 13); tick();
    bus.EX_memread = 1; bus.EX_rt = 2; #1;
    chk("clr_pre_stall", bus.PC_EN, 0);
    chk("clr_pre_rw", bus.reg_write, 1);
    CLR = 1; #2;
    chk("clr_async_rw", bus.reg_write, 0);
    chk("clr_async_pc", bus.pc_out, 0);
    chk("clr_no_stale_stall", bus.PC_EN, 1);
    bus.EX_memread = 0; tick();
    CLR = 0;
    drive(32'h00441820, 14); tick();
    drive(0, 0); tick();
    chk("clr_rf_rs", bus.rs_data, 0);
    chk("clr_rf_rt", bus.rt_data, 0);
    chk("clr_add_dest", bus.dest, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage pipeline. It sits directly downstream of the fetch stage and owns the IF/ID latch, the 32×32 register file, the main decoder and the ID/EX latch. It resolves J/JAL/JR in ID and drives the jump controls and PC enable back to fetch. It also detects load-use hazards and inserts bubbles on stalls and on branch flushes from EX.

## Interface
- PC_WIDTH, 32, width of word-index PC carried through the pipe
- clk  in  1  rising-edge clock
- CLR  in  1  asynchronous active-high reset
- IR_in  in  32  instruction from fetch
- PC_in  in  PC_WIDTH  word-index PC of IR_in
- flush  in  1  EX branch taken this cycle
- EX_memread  in  1  instruction in EX is lw
- EX_rt  in  5  destination of that lw
- WB_we  in  1  register-file write enable
- WB_addr  in  5  write address
- WB_data  in  32  write data
- PC_EN  out  1  fetch may advance (low = stall)
- J, JAL, JR  out  1 each  jump taken from ID (combinational)
- Jaddr  out  PC_WIDTH  jump target word index
- rs_data, rt_data  out  32  ID/EX operands
- imm_ext  out  32  sign-extended IR[15:0]
- dest  out  5  destination register
- reg_write, mem_read, mem_write, alu_src, branch, link  out  1 each  ID/EX controls
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- br_target  out  PC_WIDTH  PC+1+imm_ext (low PC_WIDTH bits)
- pc_out  out  PC_WIDTH  PC of the ID/EX instruction

## Operation
- Decoded set:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
  - Any other encoding, including all-zero, is a NOP with all controls 0.
- Destinations: R-type → rd; addi/lw → rt; jal → 31 with link=1.
- alu_src=1 for addi/lw/sw; beq uses sub with branch=1.
- Register file:
  - r0 always reads 0.
  - Write occurs on the clk edge when WB_we && WB_addr≠0.
  - Reads bypass: if WB_we && WB_addr≠0 && WB_addr matches the source, the read returns WB_data the same cycle.
- Jaddr:
  - J/JAL: zero-extended IR[25:0], truncated to PC_WIDTH.
  - JR: bypassed rs_data (low PC_WIDTH bits).
- Hazard (stall) = EX_memread && EX_rt≠0 && (EX_rt==rs || (EX_rt==rt && instruction reads rt)).
  - Instructions that read rt: R-type except jr, sw, beq.
- PC_EN = !stall.
- J/JAL/JR are asserted only when the decoded instruction is that jump, stall=0 and flush=0.
- Priority at each edge: CLR > flush > stall > jump > normal.
  - flush: IF/ID ← NOP, ID/EX ← bubble.
  - stall: IF/ID holds, ID/EX ← bubble.
  - jump: IF/ID ← NOP (squash the wrong-path fetch), ID/EX ← decoded jump. JR and J carry reg_write=0; JAL carries link and dest 31.
  - normal: IF/ID ← IR_in/PC_in, ID/EX ← decoded fields.
- Bubble: all control outputs 0, dest 0; data fields are don't-care but driven 0.

## Timing
- CLR asserted, asynchronously:
  - IF/ID = NOP with PC 0, ID/EX = bubble, all register-file entries 0.
  - Outputs: PC_EN=1, jump outputs 0, all registered outputs 0.
- The IR/PC presented on cycle n enters IF/ID at edge n; its ID/EX outputs appear after edge n+1 (2-edge latency).
- J/JAL/JR/Jaddr/PC_EN are combinational from the IF/ID latch and EX inputs and are valid within cycle n+1.
- A load-use stall lasts exactly one cycle: the lw moves to MEM and EX_memread drops.
- flush and stall in the same cycle: flush wins, and the held instruction is discarded.
- CLR released mid-stall: the pipe resumes from NOP state; no stale stall.
- A WB write and a read of the same register in the same cycle return the new data, including for the JR target.

## Test plan
- Reset: after CLR, all registered outputs are 0, PC_EN=1 and J/JAL/JR=0. After release, IR_in 0x00000000 yields the bubble pattern.
- addi r1,r0,5 (0x20010005) at PC 3 → two edges later: dest=1, reg_write=1, alu_src=1, imm_ext=5, alu_op=000, pc_out=3.
- Load-use: EX_memread=1, EX_rt=2, ID holds add r3,r2,r4 → PC_EN=0 for one cycle, ID/EX bubble, IF/ID held. Next cycle with EX_memread=0 → the add issues.
- jal 0x10 (0x0C000010) at PC 7 → JAL=1, Jaddr=0x10; next edge IF/ID=NOP. ID/EX: dest=31, link=1, pc_out=7.
- jr r5 while WB_we=1, WB_addr=5, WB_data=0x1C → JR=1, Jaddr=0x1C via bypass. The same jr with EX_memread=1, EX_rt=5 → JR=0, PC_EN=0.
- beq r1,r2,-2 (0x1022FFFE) at PC 9 → br_target=8, branch=1, alu_op=001. flush=1 on the following cycle → IF/ID NOP and ID/EX bubble on the next edge.
